// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request port between the icache and the dcache,
// tracks which requester owns each outstanding load tag, and steers load returns
// back to that owner.
module mem_arbiter #(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  icache2mem_command,
  input  logic [63:0] icache2mem_addr,
  input  logic [1:0]  dcache2mem_command,
  input  logic [63:0] dcache2mem_addr,
  input  logic [63:0] dcache2mem_data,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [3:0]  mem2icache_response,
  output logic [3:0]  mem2dcache_response,
  output logic [63:0] mem2icache_data,
  output logic [63:0] mem2dcache_data,
  output logic [3:0]  mem2icache_tag,
  output logic [3:0]  mem2dcache_tag,
  output logic        arb_error_o
);

  localparam int unsigned CMD_W  = 2;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 4;

  localparam logic [CMD_W-1:0] BUS_NONE  = CMD_W'(0);
  localparam logic [CMD_W-1:0] BUS_LOAD  = CMD_W'(1);
  localparam logic [CMD_W-1:0] BUS_STORE = CMD_W'(2);

  // Requester identity: 1 = dcache, 0 = icache.
  localparam logic OWN_ICACHE = 1'b0;
  localparam logic OWN_DCACHE = 1'b1;

  logic         lock_valid_q, lock_valid_d;
  logic         lock_owner_q, lock_owner_d;
  logic         last_grant_q, last_grant_d;
  logic [15:1]  tag_valid_q, tag_valid_d;
  logic [15:1]  tag_owner_q, tag_owner_d;
  logic         arb_error_q, arb_error_d;

  logic             i_act, d_act, lock_hit, grant, winner;
  logic [CMD_W-1:0] win_cmd;
  logic             accepted, ret_hit;

  // Arbitration and request-port muxing.
  always_comb begin
    i_act    = (icache2mem_command == BUS_LOAD);
    d_act    = (dcache2mem_command == BUS_LOAD) || (dcache2mem_command == BUS_STORE);
    grant    = i_act || d_act;
    // A lock only holds while its owner keeps requesting.
    lock_hit = lock_valid_q && (lock_owner_q ? d_act : i_act);
    if (lock_hit)          winner = lock_owner_q;
    else if (i_act && d_act) winner = ~last_grant_q;
    else                   winner = d_act;

    win_cmd             = BUS_NONE;
    proc2mem_command    = BUS_NONE;
    proc2mem_addr       = '0;
    proc2mem_data       = '0;
    mem2icache_response = '0;
    mem2dcache_response = '0;
    if (grant) begin
      if (winner == OWN_DCACHE) begin
        win_cmd             = dcache2mem_command;
        proc2mem_addr       = dcache2mem_addr;
        proc2mem_data       = dcache2mem_data;
        mem2dcache_response = mem2proc_response;
      end else begin
        win_cmd             = BUS_LOAD;
        proc2mem_addr       = icache2mem_addr;
        mem2icache_response = mem2proc_response;
      end
      proc2mem_command = win_cmd;
    end
    accepted = grant && (mem2proc_response != TAG_W'(0));
  end

  // Load-return steering through the owner table.
  always_comb begin
    ret_hit         = 1'b0;
    mem2icache_data = '0;
    mem2icache_tag  = '0;
    mem2dcache_data = '0;
    mem2dcache_tag  = '0;
    if ((mem2proc_tag != TAG_W'(0)) && tag_valid_q[mem2proc_tag]) begin
      ret_hit = 1'b1;
      if (tag_owner_q[mem2proc_tag] == OWN_DCACHE) begin
        mem2dcache_data = mem2proc_data;
        mem2dcache_tag  = mem2proc_tag;
      end else begin
        mem2icache_data = mem2proc_data;
        mem2icache_tag  = mem2proc_tag;
      end
    end
  end

  // Next-state for lock, round-robin pointer, owner table and error flag.
  always_comb begin
    lock_valid_d = 1'b0;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    tag_valid_d  = tag_valid_q;
    tag_owner_d  = tag_owner_q;
    arb_error_d  = arb_error_q;

    if (grant && !accepted) begin
      lock_valid_d = 1'b1;
      lock_owner_d = winner;
    end
    if (accepted) last_grant_d = winner;

    if (ret_hit) tag_valid_d[mem2proc_tag] = 1'b0;
    else if (mem2proc_tag != TAG_W'(0)) arb_error_d = 1'b1;

    // Allocation comes after the clear so a same-cycle reuse of a tag wins.
    if (accepted && (win_cmd == BUS_LOAD)) begin
      tag_valid_d[mem2proc_response] = 1'b1;
      tag_owner_d[mem2proc_response] = winner;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= OWN_ICACHE;
      last_grant_q <= DCACHE_FIRST ? OWN_ICACHE : OWN_DCACHE;
      tag_valid_q  <= '0;
      tag_owner_q  <= '0;
      arb_error_q  <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_owner_q  <= tag_owner_d;
      arb_error_q  <= arb_error_d;
    end
  end

  assign arb_error_o = arb_error_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against hand-computed expectations.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  icache2mem_command;
  logic [63:0] icache2mem_addr;
  logic [1:0]  dcache2mem_command;
  logic [63:0] dcache2mem_addr;
  logic [63:0] dcache2mem_data;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [3:0]  mem2icache_response;
  logic [3:0]  mem2dcache_response;
  logic [63:0] mem2icache_data;
  logic [63:0] mem2dcache_data;
  logic [3:0]  mem2icache_tag;
  logic [3:0]  mem2dcache_tag;
  logic        arb_error_o;

  int n_checks;
  int n_errors;

  mem_arbiter #(.DCACHE_FIRST(1'b1)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache2mem_command  (icache2mem_command),
    .icache2mem_addr     (icache2mem_addr),
    .dcache2mem_command  (dcache2mem_command),
    .dcache2mem_addr     (dcache2mem_addr),
    .dcache2mem_data     (dcache2mem_data),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_data       (mem2proc_data),
    .mem2proc_tag        (mem2proc_tag),
    .mem2icache_response (mem2icache_response),
    .mem2dcache_response (mem2dcache_response),
    .mem2icache_data     (mem2icache_data),
    .mem2dcache_data     (mem2dcache_data),
    .mem2icache_tag      (mem2icache_tag),
    .mem2dcache_tag      (mem2dcache_tag),
    .arb_error_o         (arb_error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs just after the rising edge, then let them settle.
  task automatic drive(input logic [1:0] ic, input logic [63:0] ia,
                       input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] md);
    @(posedge clk);
    #1;
    icache2mem_command = ic;
    icache2mem_addr    = ia;
    dcache2mem_command = dc;
    dcache2mem_addr    = da;
    dcache2mem_data    = dd;
    mem2proc_response  = resp;
    mem2proc_tag       = tag;
    mem2proc_data      = md;
    #1;
  endtask

  task automatic idle(input logic [3:0] tag, input logic [63:0] md);
    drive(2'd0, 64'h0, 2'd0, 64'h0, 64'h0, 4'd0, tag, md);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    icache2mem_command = 2'd0; icache2mem_addr = '0;
    dcache2mem_command = 2'd0; dcache2mem_addr = '0; dcache2mem_data = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    #2;
    check("rst_cmd", 64'(proc2mem_command), 64'd0);
    check("rst_addr", proc2mem_addr, 64'd0);
    check("rst_err", 64'(arb_error_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // First conflict after reset goes to dcache, then round-robin to icache.
    drive(2'd1, 64'hA0, 2'd1, 64'hB0, 64'h55, 4'd3, 4'd0, 64'h0);
    check("rr1_addr", proc2mem_addr, 64'hB0);
    check("rr1_data", proc2mem_data, 64'h55);
    check("rr1_dresp", 64'(mem2dcache_response), 64'd3);
    check("rr1_iresp", 64'(mem2icache_response), 64'd0);
    drive(2'd1, 64'hA0, 2'd1, 64'hB0, 64'h55, 4'd6, 4'd0, 64'h0);
    check("rr2_addr", proc2mem_addr, 64'hA0);
    check("rr2_data", proc2mem_data, 64'h0);
    check("rr2_iresp", 64'(mem2icache_response), 64'd6);
    check("rr2_dresp", 64'(mem2dcache_response), 64'd0);
    idle(4'd3, 64'h33);
    check("ret3_dtag", 64'(mem2dcache_tag), 64'd3);
    check("ret3_ddata", mem2dcache_data, 64'h33);
    check("ret3_itag", 64'(mem2icache_tag), 64'd0);
    idle(4'd6, 64'h66);
    check("ret6_itag", 64'(mem2icache_tag), 64'd6);
    check("ret6_idata", mem2icache_data, 64'h66);
    check("ret6_dtag", 64'(mem2dcache_tag), 64'd0);

    // Lock holds icache on the bus against a round-robin-favoured dcache store.
    drive(2'd1, 64'h100, 2'd0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    check("lk0_addr", proc2mem_addr, 64'h100);
    drive(2'd1, 64'h100, 2'd2, 64'h200, 64'h77, 4'd0, 4'd0, 64'h0);
    check("lk1_addr", proc2mem_addr, 64'h100);
    check("lk1_cmd", 64'(proc2mem_command), 64'd1);
    check("lk1_dresp", 64'(mem2dcache_response), 64'd0);
    drive(2'd1, 64'h100, 2'd2, 64'h200, 64'h77, 4'd5, 4'd0, 64'h0);
    check("lk2_addr", proc2mem_addr, 64'h100);
    check("lk2_iresp", 64'(mem2icache_response), 64'd5);
    drive(2'd1, 64'h100, 2'd2, 64'h200, 64'h77, 4'd4, 4'd0, 64'h0);
    check("lk3_addr", proc2mem_addr, 64'h200);
    check("lk3_cmd", 64'(proc2mem_command), 64'd2);
    check("lk3_data", proc2mem_data, 64'h77);
    check("lk3_dresp", 64'(mem2dcache_response), 64'd4);
    check("lk3_iresp", 64'(mem2icache_response), 64'd0);
    idle(4'd5, 64'h55);
    check("ret5_itag", 64'(mem2icache_tag), 64'd5);

    // Locked icache drops its request: dcache wins in the same cycle.
    drive(2'd1, 64'h300, 2'd0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    drive(2'd0, 64'h300, 2'd1, 64'h400, 64'h0, 4'd11, 4'd0, 64'h0);
    check("drop_addr", proc2mem_addr, 64'h400);
    check("drop_dresp", 64'(mem2dcache_response), 64'd11);
    idle(4'd11, 64'hBB);
    check("ret11_dtag", 64'(mem2dcache_tag), 64'd11);
    check("ret11_ddata", mem2dcache_data, 64'hBB);

    // icache load tag 7 returned three cycles later.
    drive(2'd1, 64'h500, 2'd0, 64'h0, 64'h0, 4'd7, 4'd0, 64'h0);
    check("t7_iresp", 64'(mem2icache_response), 64'd7);
    idle(4'd0, 64'h0);
    idle(4'd0, 64'h0);
    idle(4'd7, 64'hDEAD);
    check("ret7_itag", 64'(mem2icache_tag), 64'd7);
    check("ret7_idata", mem2icache_data, 64'hDEAD);
    check("ret7_dtag", 64'(mem2dcache_tag), 64'd0);
    check("ret7_ddata", mem2dcache_data, 64'd0);

    // Tag 9 returned to dcache while reallocated to icache in the same cycle.
    drive(2'd0, 64'h0, 2'd1, 64'h580, 64'h0, 4'd9, 4'd0, 64'h0);
    check("t9_dresp", 64'(mem2dcache_response), 64'd9);
    drive(2'd1, 64'h600, 2'd0, 64'h0, 64'h0, 4'd9, 4'd9, 64'h99);
    check("re9_ddata", mem2dcache_data, 64'h99);
    check("re9_dtag", 64'(mem2dcache_tag), 64'd9);
    check("re9_itag", 64'(mem2icache_tag), 64'd0);
    check("re9_iresp", 64'(mem2icache_response), 64'd9);
    idle(4'd9, 64'hAB);
    check("ret9_itag", 64'(mem2icache_tag), 64'd9);
    check("ret9_idata", mem2icache_data, 64'hAB);
    check("ret9_dtag", 64'(mem2dcache_tag), 64'd0);
    check("ret9_err", 64'(arb_error_o), 64'd0);

    // Return of a store tag is unowned: not forwarded, sticky error.
    idle(4'd4, 64'h44);
    check("st4_itag", 64'(mem2icache_tag), 64'd0);
    check("st4_dtag", 64'(mem2dcache_tag), 64'd0);
    check("st4_ddata", mem2dcache_data, 64'd0);
    check("st4_err_pre", 64'(arb_error_o), 64'd0);
    idle(4'd0, 64'h0);
    check("st4_err", 64'(arb_error_o), 64'd1);
    idle(4'd7, 64'h1);
    check("stale7_itag", 64'(mem2icache_tag), 64'd0);
    check("err_hold", 64'(arb_error_o), 64'd1);

    // Mid-cycle reset with tag 2 outstanding and an icache lock held.
    drive(2'd1, 64'h800, 2'd0, 64'h0, 64'h0, 4'd2, 4'd0, 64'h0);
    check("t2_iresp", 64'(mem2icache_response), 64'd2);
    drive(2'd1, 64'h800, 2'd0, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    drive(2'd1, 64'h800, 2'd1, 64'h900, 64'h0, 4'd0, 4'd0, 64'h0);
    check("prerst_addr", proc2mem_addr, 64'h800);
    rst = 1'b1;
    #1;
    check("rst_mid_addr", proc2mem_addr, 64'h900);
    check("rst_mid_err", 64'(arb_error_o), 64'd0);
    rst = 1'b0;
    #1;
    idle(4'd2, 64'h22);
    check("ret2_itag", 64'(mem2icache_tag), 64'd0);
    check("ret2_idata", mem2icache_data, 64'd0);
    idle(4'd0, 64'h0);
    check("ret2_err", 64'(arb_error_o), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
